// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential bus fetches ahead of the pipeline and buffers {word, pc}.
// Optional combinational FIFO bypass on empty queue is enabled with `define FETCH_BYPASS_EN.
module inst_prefetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h00400000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        next_inst,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_available,
  output logic [31:0] pc,
  output logic        inst_read_enable,
  input  logic        inst_wait_req,
  input  logic        inst_valid,
  input  logic [31:0] inst_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] SH_LAST = SW'(MAX_OUTSTANDING - 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   data_mem   [DEPTH];
  logic [31:0]   pc_mem     [DEPTH];
  logic [31:0]   shadow_mem [MAX_OUTSTANDING];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [SW-1:0] sh_rd, sh_wr;
  logic [CW-1:0] count, outstanding, drop;

  logic          accept, resp_drop, resp_live, push, pop, bypass_hit;
  logic [CW-1:0] out_upd, drop_upd, count_upd;
  logic [31:0]   shadow_pc;
  logic          pc_low_unused;

  assign pc_low_unused = ^redirect_pc[1:0];
  assign shadow_pc     = shadow_mem[sh_rd];
  assign pc            = fetch_pc;

  function automatic logic [SW-1:0] sh_next(input logic [SW-1:0] p);
    return (p == SH_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inst_read_enable = 1'b0;
    bypass_hit       = 1'b0;
    inst_available   = 1'b0;
    inst             = '0;
    inst_pc          = '0;

    // Dropped responses still occupy bus slots, so they gate issue alongside live ones.
    inst_read_enable = reset && !redirect &&
                       ((outstanding + drop) < MAX_C) &&
                       ((count + outstanding) < DEPTH_C);
    accept    = inst_read_enable && !inst_wait_req;
    resp_drop = inst_valid && (drop != '0);
    resp_live = inst_valid && (drop == '0);

`ifdef FETCH_BYPASS_EN
    bypass_hit = resp_live && !redirect && (count == '0);
`else
    bypass_hit = 1'b0;
`endif

    pop  = next_inst && (count != '0) && !redirect;
    push = resp_live && !redirect && !(bypass_hit && next_inst);

    inst_available = (count != '0) || bypass_hit;
    if (count != '0) begin
      inst    = data_mem[rd_ptr];
      inst_pc = pc_mem[rd_ptr];
    end else if (bypass_hit) begin
      inst    = inst_data;
      inst_pc = shadow_pc;
    end

    out_upd   = outstanding + CW'(accept) - CW'(resp_live);
    drop_upd  = drop - CW'(resp_drop);
    count_upd = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      sh_rd       <= '0;
      sh_wr       <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect) begin
      // No accept can happen this cycle, so every pending shadow tag belongs to a now-dead request.
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      sh_rd       <= sh_wr;
      count       <= '0;
      outstanding <= '0;
      drop        <= drop_upd + out_upd;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
        sh_wr    <= sh_next(sh_wr);
      end
      if (resp_live) sh_rd  <= sh_next(sh_rd);
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      count       <= count_upd;
      outstanding <= out_upd;
      drop        <= drop_upd;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr] <= inst_data;
      pc_mem[wr_ptr]   <= shadow_pc;
    end
    if (accept) shadow_mem[sh_wr] <= fetch_pc;
  end

endmodule
